// File: rtl/gray_vector_sequencer_if.sv
// Stimulus/response bundle between the Gray sequencer and the two
// implementations it compares.
interface gray_vector_sequencer_if;
  logic       start;
  logic [1:0] y_ref;
  logic [1:0] y_dut;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic [3:0] mismatch_cnt;
  logic       fail_valid;
  logic [2:0] first_fail_vec;

  modport master (
    output start, y_ref, y_dut,
    input  a, b, c, busy, done, mismatch_cnt, fail_valid, first_fail_vec
  );

  modport slave (
    input  start, y_ref, y_dut,
    output a, b, c, busy, done, mismatch_cnt, fail_valid, first_fail_vec
  );
endinterface

// File: rtl/gray_vector_sequencer.sv
// Drives {a,b,c} through the 3-bit Gray sequence, DWELL cycles per vector,
// and scores the reference/candidate outputs at the end of each dwell.
module gray_vector_sequencer #(
  parameter int DWELL = 50,
  parameter int CW    = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  gray_vector_sequencer_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    abc_q, abc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    mcnt_q, mcnt_d;
  logic          fail_q, fail_d;
  logic [2:0]    first_q, first_d;
  logic [2:0]    idx_nxt;
  logic          mism;

  assign idx_nxt = idx_q + 3'd1;
  // Case inequality so an X/Z on either side is scored as a failure.
  assign mism    = (bus.y_ref !== bus.y_dut);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    abc_d   = abc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mcnt_d  = mcnt_q;
    fail_d  = fail_q;
    first_d = first_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          abc_d   = '0;
          mcnt_d  = '0;
          fail_d  = 1'b0;
          first_d = '0;
        end
      end
      RUN: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          if (mism) begin
            mcnt_d = mcnt_q + 4'd1;
            if (!fail_q) begin
              fail_d  = 1'b1;
              first_d = abc_q;
            end
          end
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
            abc_d   = '0;
          end else begin
            idx_d = idx_nxt;
            abc_d = idx_nxt ^ (idx_nxt >> 1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mcnt_q  <= '0;
      fail_q  <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mcnt_q  <= mcnt_d;
      fail_q  <= fail_d;
      first_q <= first_d;
    end
  end

  assign {bus.a, bus.b, bus.c} = abc_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.mismatch_cnt      = mcnt_q;
  assign bus.fail_valid        = fail_q;
  assign bus.first_fail_vec    = first_q;

endmodule

// File: doc/gray_vector_sequencer.md
Name: gray_vector_sequencer

Overview:
- Synchronous stimulus controller for the 3-input logic comparison datapath.
- Walks inputs a,b,c through the 8-entry Gray sequence, holding each vector for DWELL cycles.
- Samples the reference (gate-level) and candidate (switch-level) output pairs at the end of each dwell, then counts and records mismatches.
- Sits between a run trigger and the two implementations under comparison; replaces hand-timed stimulus with a repeatable, self-checking sequence.

Parameters:
- DWELL, 50, clock cycles each vector is held; legal range 2..1023.
- CW, 10, width of the dwell counter; must satisfy 2^CW >= DWELL.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle run request; honoured only in IDLE or DONE
- y_ref  input  2  reference outputs {Y1,Y0}
- y_dut  input  2  candidate outputs {Y1_s,Y0_s}
- a  output  1  stimulus MSB
- b  output  1  stimulus middle bit
- c  output  1  stimulus LSB
- busy  output  1  high while the sequence is running
- done  output  1  high from sequence end until the next start or rst
- mismatch_cnt  output  4  number of vectors that failed, 0..8
- fail_valid  output  1  high once any mismatch has been recorded in the run
- first_fail_vec  output  3  {a,b,c} of the first failing vector; valid only when fail_valid=1

Behaviour:
- Reset: rst is sampled at the rising edge of clk. Next cycle: state=IDLE; a,b,c=0; busy=0; done=0; mismatch_cnt=0; fail_valid=0; first_fail_vec=0; dwell counter=0; vector index=0.
- Reset mid-run: rst has priority over every other input and the run is abandoned. No partial result is retained.
- Sequence, index 0..7, as {a,b,c}: 000, 001, 011, 010, 110, 111, 101, 100. Generated as idx ^ (idx>>1).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Outputs hold their reset values.
  - start=1 at edge t: from t+1, state=RUN, busy=1, abc=000, idx=0, cnt=0.
  - The same edge clears mismatch_cnt, fail_valid and first_fail_vec.
- RUN:
  - cnt increments every cycle.
  - At the edge where cnt==DWELL-1, y_ref and y_dut are compared.
  - Mismatch: any bit of y_ref differs from y_dut. An X/Z on either input counts as a mismatch, so the compare uses case inequality.
  - On a mismatch: mismatch_cnt increments. If fail_valid=0, first_fail_vec takes the current {a,b,c} and fail_valid goes to 1 at the same edge.
  - At that same edge: if idx<7, idx increments, cnt returns to 0 and abc takes the next Gray vector.
  - If idx==7: state=DONE, busy=0, done=1, abc=000, idx=0.
- DONE:
  - abc is held at 000; results and done are held.
  - start=1 re-enters RUN with the same timing as from IDLE; done falls at that edge.
- Latency: busy is high for exactly 8*DWELL cycles. done rises 8*DWELL cycles after the first busy cycle.
- start while busy is ignored. It does not restart or extend the run.
- mismatch_cnt cannot exceed 8, so no wrap can occur. No saturation logic is needed beyond the 4-bit width.
- Each abc vector is stable for DWELL full cycles. Exactly one bit changes per vector transition, except the final return to 000 (100→000, also one bit).
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Pass run:
  - Stimulus: DWELL=4; rst 2 cycles; pulse start; tie y_dut=y_ref from a correct model.
  - Required: abc steps 000,001,011,010,110,111,101,100, 4 cycles each; busy high 32 cycles; then done=1, mismatch_cnt=0, fail_valid=0, abc=000.
- Single fault:
  - Stimulus: force y_dut[0] inverted only while abc=011.
  - Required: mismatch_cnt=1, fail_valid=1, first_fail_vec=3'b011.
- Multiple faults and X input:
  - Stimulus: y_dut=2'bxx for vectors 010 and 100, and y_dut[1] inverted at 111.
  - Required: mismatch_cnt=3, first_fail_vec=3'b010.
- Late glitch not sampled:
  - Stimulus: mismatch present only in cycles 0..DWELL-2 of each vector.
  - Required: mismatch_cnt=0.
- Reset mid-run:
  - Stimulus: assert rst during vector 110 after two recorded failures.
  - Required: next cycle all outputs are at reset values; a subsequent start gives a clean 32-cycle run.
- start handling:
  - Stimulus: pulse start while busy at vector 001.
  - Required: no restart; done at the original time.
  - Stimulus: pulse start while done.
  - Required: done falls, results clear and a new run begins the next cycle.
